// File: rtl/rotate_right_seq_pkg.sv
// Shared definitions for the sequential rotate-right unit.
//   state_e       : FSM state encoding (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10)
//   DefaultWidth  : default data width of rotate_right_seq
package rotate_right_seq_pkg;

  localparam int unsigned DefaultWidth = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } state_e;

endpackage

// File: rtl/rotate_right_stage.sv
// One combinational stage of the log-shifter: rotates (or, with Op=1, logically
// shifts) the operand right by Amt when En is set, otherwise passes it through.
// Optional build macro: ROTR_SHR_OP_EN adds the Op input.
// Ports:
//   In  [WIDTH] operand
//   Amt [CW]    shift amount (a single power of two in normal use)
//   En          apply this stage
//   Op          0 = rotate, 1 = logical shift (only with ROTR_SHR_OP_EN)
//   Out [WIDTH] result
module rotate_right_stage #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CW    = 4
) (
  input  logic [WIDTH-1:0] In,
  input  logic [CW-1:0]    Amt,
  input  logic             En,
`ifdef ROTR_SHR_OP_EN
  input  logic             Op,
`endif
  output logic [WIDTH-1:0] Out
);

  logic [2*WIDTH-1:0] dbl;
  logic [WIDTH-1:0]   rotated;

  // Shifting the doubled word right leaves the wrapped bits in the low half.
  assign dbl     = {In, In} >> Amt;
  assign rotated = dbl[WIDTH-1:0];

`ifdef ROTR_SHR_OP_EN
  logic [WIDTH-1:0] shifted;
  assign shifted = In >> Amt;
  assign Out     = En ? (Op ? shifted : rotated) : In;
`else
  assign Out     = En ? rotated : In;
`endif

endmodule

// File: rtl/rotate_right_seq.sv
// Sequential rotate-right unit: rotates In right by Cnt, one binary stage per
// clock, MSB stage first, giving a fixed latency of CW cycles.
// Optional build macro: ROTR_SHR_OP_EN adds input Op (0 = rotate, 1 = logical
// shift right); timing and handshake are unchanged.
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   Start       request, sampled on the rising edge
//   In  [WIDTH] operand, captured with Start
//   Cnt [CW]    rotate amount, captured with Start
//   Op          rotate/shift select, captured with Start (ROTR_SHR_OP_EN only)
//   Out [WIDTH] registered result, held until the next completion
//   Busy        high while an operation is in progress
//   Done        one-cycle completion pulse, Out valid in the same cycle
module rotate_right_seq
  import rotate_right_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  localparam int unsigned CW   = $clog2(WIDTH),
  localparam int unsigned SW   = (CW > 1) ? $clog2(CW) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] In,
  input  logic [CW-1:0]    Cnt,
`ifdef ROTR_SHR_OP_EN
  input  logic             Op,
`endif
  output logic [WIDTH-1:0] Out,
  output logic             Busy,
  output logic             Done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    count_q, count_d;
  logic [SW-1:0]    stage_q, stage_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] stage_out;
  logic [CW-1:0]    stage_amt;
  logic             stage_en;

`ifdef ROTR_SHR_OP_EN
  logic op_q, op_d;
`endif

  // Current stage weight is 2^stage; it is applied only if that bit of the count is set.
  assign stage_amt = CW'(1) << stage_q;
  assign stage_en  = count_q[stage_q];

  rotate_right_stage #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_stage (
    .In  (data_q),
    .Amt (stage_amt),
    .En  (stage_en),
`ifdef ROTR_SHR_OP_EN
    .Op  (op_q),
`endif
    .Out (stage_out)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    stage_d = stage_q;
    out_d   = out_q;
`ifdef ROTR_SHR_OP_EN
    op_d    = op_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (Start) begin
          state_d = StShift;
          data_d  = In;
          count_d = Cnt;
          stage_d = SW'(CW - 1);
`ifdef ROTR_SHR_OP_EN
          op_d    = Op;
`endif
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        // Start is deliberately ignored here: no queuing.
        data_d = stage_out;
        if (stage_q == '0) begin
          out_d   = stage_out;
          state_d = StDone;
        end else begin
          stage_d = stage_q - SW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      data_q  <= '0;
      count_q <= '0;
      stage_q <= '0;
      out_q   <= '0;
`ifdef ROTR_SHR_OP_EN
      op_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
      stage_q <= stage_d;
      out_q   <= out_d;
`ifdef ROTR_SHR_OP_EN
      op_q    <= op_d;
`endif
    end
  end

  assign Out  = out_q;
  assign Busy = (state_q == StShift);
  assign Done = (state_q == StDone);

endmodule
